// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, Req generation.
// Ports: en/CP0Add/CP0In mtc0; VPC/BDIn/ExcCodeIn/HWInt/EXLClr commit; CP0Out/EPCOut/Req.
module cp0_exc_ctrl #(
  parameter int HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [4:0]          CP0Add,
  input  logic [31:0]         CP0In,
  input  logic [31:0]         VPC,
  input  logic                BDIn,
  input  logic [4:0]          ExcCodeIn,
  input  logic [HW_INT_W-1:0] HWInt,
  input  logic                EXLClr,
  output logic [31:0]         CP0Out,
  output logic [31:0]         EPCOut,
  output logic                Req
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;

  logic [HW_INT_W-1:0] sr_im_q, sr_im_d;
  logic                sr_exl_q, sr_exl_d;
  logic                sr_ie_q, sr_ie_d;
  logic                cause_bd_q, cause_bd_d;
  logic [HW_INT_W-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]          cause_exc_q, cause_exc_d;
  // EPC is word aligned; only bits [31:2] are stored.
  logic [31:2]         epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_src;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic        unused_bits;

  assign int_req = (|(HWInt & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl_q;
  assign Req     = int_req | exc_req;

  // A delay-slot instruction restarts at its branch.
  assign epc_src = BDIn ? (VPC - 32'd4) : VPC;

  assign unused_bits = ^{CP0In, epc_src[1:0]};

  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_ip_d  = HWInt;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (Req) begin
      // The trapping instruction does not commit: its mtc0 is dropped.
      sr_exl_d    = 1'b1;
      cause_exc_d = int_req ? 5'd0 : ExcCodeIn;
      cause_bd_d  = BDIn;
      epc_d       = epc_src[31:2];
    end else begin
      if (en && CP0Add == ADDR_SR) begin
        sr_im_d  = CP0In[10 +: HW_INT_W];
        sr_exl_d = CP0In[1];
        sr_ie_d  = CP0In[0];
      end
      if (en && CP0Add == ADDR_EPC) begin
        epc_d = CP0In[31:2];
      end
      if (EXLClr) begin
        sr_exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im_q     <= '0;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_word               = '0;
    sr_word[10 +: HW_INT_W] = sr_im_q;
    sr_word[1]            = sr_exl_q;
    sr_word[0]            = sr_ie_q;
  end

  always_comb begin
    cause_word               = '0;
    cause_word[31]           = cause_bd_q;
    cause_word[10 +: HW_INT_W] = cause_ip_q;
    cause_word[6:2]          = cause_exc_q;
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      ADDR_SR:    CP0Out = sr_word;
      ADDR_CAUSE: CP0Out = cause_word;
      ADDR_EPC:   CP0Out = {epc_q, 2'b00};
      default:    CP0Out = '0;
    endcase
  end

  assign EPCOut = {epc_q, 2'b00};

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Testbench for cp0_exc_ctrl: directed plan steps plus random traffic
// checked against a word-level reference model of SR/Cause/EPC.
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [4:0]  CP0Add;
  logic [31:0] CP0In;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] CP0Out;
  logic [31:0] EPCOut;
  logic        Req;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_sr, m_cause, m_epc;
  logic [31:0] r12, r13, r14, r_oth;
  logic        req_obs;

  always #10 clk = ~clk;

  cp0_exc_ctrl #(.HW_INT_W(6)) dut (
    .clk(clk), .reset(reset), .en(en), .CP0Add(CP0Add),
    .CP0In(CP0In), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
    .HWInt(HWInt), .EXLClr(EXLClr), .CP0Out(CP0Out),
    .EPCOut(EPCOut), .Req(Req)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  function automatic bit m_int();
    return ((32'(HWInt) << 10) & m_sr) != 0 && m_sr[0] && !m_sr[1];
  endfunction

  function automatic bit m_exc();
    return ExcCodeIn != 0 && !m_sr[1];
  endfunction

  task automatic m_step();
    bit ir, er;
    ir = m_int();
    er = m_exc();
    if (reset) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
    end else begin
      m_cause = (m_cause & 32'h8000007C) | (32'(HWInt) << 10);
      if (ir || er) begin
        m_sr    = m_sr | 32'd2;
        m_epc   = (BDIn ? VPC - 32'd4 : VPC) & 32'hFFFFFFFC;
        m_cause = (BDIn ? 32'h80000000 : 32'd0) | (32'(HWInt) << 10)
                | (ir ? 32'd0 : 32'(ExcCodeIn) << 2);
      end else begin
        if (en && CP0Add == 5'd12) m_sr = CP0In & 32'h0000FC03;
        if (en && CP0Add == 5'd14) m_epc = CP0In & 32'hFFFFFFFC;
        if (EXLClr) m_sr = m_sr & ~32'd2;
      end
    end
  endtask

  // Inputs are already set; sample state, check Req, then clock once.
  task automatic do_cycle();
    logic [4:0] a;
    logic [4:0] o;
    a = CP0Add;
    o = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 11))
                                     : 5'($urandom_range(15, 31));
    CP0Add = 5'd12; #1 r12 = CP0Out; check("rd_sr", r12, m_sr);
    CP0Add = 5'd13; #1 r13 = CP0Out; check("rd_cause", r13, m_cause);
    CP0Add = 5'd14; #1 r14 = CP0Out; check("rd_epc", r14, m_epc);
    CP0Add = o;     #1 r_oth = CP0Out; check("rd_other", r_oth, 32'd0);
    CP0Add = a;     #1;
    check("rd_addr", CP0Out, m_read(a));
    check("epcout", EPCOut, m_epc);
    req_obs = Req;
    check("req", 32'(req_obs), 32'(m_int() || m_exc()));
    @(posedge clk);
    #1;
    m_step();
  endtask

  task automatic idle();
    reset = 0; en = 0; CP0Add = 5'd0; CP0In = 0; VPC = 32'h3000;
    BDIn = 0; ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); en = 1; CP0Add = a; CP0In = d;
    do_cycle();
  endtask

  task automatic eret();
    idle(); EXLClr = 1;
    do_cycle();
  endtask

  initial begin
    m_sr = 0; m_cause = 0; m_epc = 0;
    idle();
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    idle();
    do_cycle();
    check("rst_sr", r12, 32'd0);
    check("rst_cause", r13, 32'd0);
    check("rst_epc", r14, 32'd0);
    check("rst_req", 32'(req_obs), 32'd0);

    // Exception capture.
    mtc0(5'd12, 32'h1);
    idle(); ExcCodeIn = 5'd12; VPC = 32'h3010;
    do_cycle();
    check("exc_req", 32'(req_obs), 32'd1);
    idle(); do_cycle();
    check("exc_epc", r14, 32'h3010);
    check("exc_code", 32'(r13[6:2]), 32'd12);
    check("exc_exl", 32'(r12[1]), 32'd1);
    check("exc_req_after", 32'(req_obs), 32'd0);

    // Delay-slot interrupt.
    eret();
    mtc0(5'd12, 32'h401);
    idle(); HWInt = 6'b000001; VPC = 32'h3024; BDIn = 1;
    do_cycle();
    check("ds_req", 32'(req_obs), 32'd1);
    idle(); HWInt = 6'b000001; do_cycle();
    check("ds_epc", r14, 32'h3020);
    check("ds_cause", r13, 32'h80000400);

    // Priority and mtc0 suppression.
    idle(); EXLClr = 1; HWInt = 6'b000001; do_cycle();
    idle(); HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h4000;
    en = 1; CP0Add = 5'd14; CP0In = 32'h1234;
    do_cycle();
    check("pri_req", 32'(req_obs), 32'd1);
    idle(); HWInt = 6'b000001; do_cycle();
    check("pri_code", 32'(r13[6:2]), 32'd0);
    check("pri_epc", r14, 32'h4000);

    // Masking by EXL, then eret releases the pending interrupt.
    check("exl_mask", 32'(req_obs), 32'd0);
    idle(); HWInt = 6'b000001; EXLClr = 1; do_cycle();
    check("eret_cyc", 32'(req_obs), 32'd0);
    idle(); HWInt = 6'b000001; do_cycle();
    check("eret_fire", 32'(req_obs), 32'd1);

    // IE=0 and IM=0 keep Req low while IP tracks.
    eret();
    mtc0(5'd12, 32'h0000FC00);
    idle(); HWInt = 6'h3F; do_cycle();
    check("ie0_req", 32'(req_obs), 32'd0);
    mtc0(5'd12, 32'h1);
    idle(); HWInt = 6'h2A; do_cycle();
    check("im0_req", 32'(req_obs), 32'd0);
    idle(); HWInt = 6'h15; do_cycle();
    check("ip_track", 32'(r13[15:10]), 32'h2A);

    // mtc0 write masking.
    idle(); do_cycle();
    mtc0(5'd12, 32'hFFFFFFFF);
    mtc0(5'd13, 32'hFFFFFFFF);
    check("wm_sr", r12, 32'h0000FC03);
    mtc0(5'd14, 32'hFFFFFFFF);
    check("wm_cause", r13, 32'h0);
    mtc0(5'd20, 32'hFFFFFFFF);
    check("wm_epc", r14, 32'hFFFFFFFC);
    idle(); CP0Add = 5'd20; do_cycle();

    // VPC wrap in delay slot.
    eret();
    idle(); ExcCodeIn = 5'd4; VPC = 32'h0; BDIn = 1; do_cycle();
    idle(); do_cycle();
    check("wrap_epc", r14, 32'hFFFFFFFC);

    // Reset overrides a pending request.
    eret();
    idle(); reset = 1; ExcCodeIn = 5'd8; VPC = 32'h5000; do_cycle();
    idle(); do_cycle();
    check("rst_ovr_sr", r12, 32'd0);
    check("rst_ovr_epc", r14, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 49) == 0);
      en     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: CP0Add = 5'd12;
        1: CP0Add = 5'd13;
        2: CP0Add = 5'd14;
        default: CP0Add = 5'($urandom_range(0, 31));
      endcase
      CP0In     = $urandom;
      VPC       = $urandom;
      BDIn      = 1'($urandom_range(0, 1));
      ExcCodeIn = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr    = ($urandom_range(0, 5) == 0);
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
